// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the data-memory arbiter that sits between the
// EX_MEM pipeline register (CPU port), the program/data loader (DMA port)
// and DataMemory.
//   arbState_t         : arbiter FSM encoding (READY = 0, ACK = 1)
//   STARVE_MAX_DEFAULT : default limit of consecutive CPU wins over a
//                        pending DMA request
//   DBG_CNT_W          : width of the debug view of the starvation counter
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic {
        READY = 1'b0,
        ACK   = 1'b1
    } arbState_t;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int DBG_CNT_W          = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the CPU, DMA and memory-side signals of the arbiter.
//   CPU : cpu_req, cpu_we, cpu_addr, cpu_wdata -> ; <- cpu_rdata, cpu_stall
//   DMA : dma_req, dma_we, dma_addr, dma_wdata -> ; <- dma_rdata, dma_ack
//   MEM : <- mem_addr, mem_wdata, mem_rd, mem_wr ; mem_rdata ->
// Modports:
//   slave  : the arbiter's view (requests and mem_rdata in)
//   master : the surrounding pipeline / loader / memory view
//
// Handshake: the CPU request is a level (cpu_req) and is served in the same
// cycle unless cpu_stall=1, in which case it must be held. The DMA request is
// held until dma_ack; dma_ack is a one-cycle pulse the cycle after the access.
// A DMA request dropped before its access is simply discarded.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic [31:0]   dma_rdata;
    logic          dma_ack;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Single-port data-memory arbiter between the CPU MEM stage and a loader.
// One owner per cycle is resolved combinationally. The CPU has priority but
// may only beat a pending DMA request STARVE_MAX times in a row; the DMA
// access is then forced and the CPU is stalled for that cycle.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : mem_arbiter_if.slave (CPU, DMA and memory signals)
//   dbgState     : current FSM state
//   dbgStarveCnt : current starvation count (zero-extended)
// The bus interface must be instantiated with the same AW as this module.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int AW         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_arbiter_if.slave         bus,
    output arbState_t            dbgState,
    output logic [DBG_CNT_W-1:0] dbgStarveCnt
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    arbState_t     state, stateNext;
    logic [CW-1:0] starveCnt, starveNext;
    logic          ackReg;
    logic [31:0]   rdataReg;

    logic dmaEligible;
    logic cpuGrant;
    logic dmaGrant;

    // Ownership and memory-port mux
    always_comb begin
        dmaEligible = bus.dma_req && (state == READY);
        cpuGrant    = bus.cpu_req && (!dmaEligible || (starveCnt < CW'(STARVE_MAX)));
        dmaGrant    = dmaEligible && !cpuGrant;

        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = 32'h0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        if (cpuGrant) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_wr    = bus.cpu_we;
            bus.mem_rd    = !bus.cpu_we;
        end else if (dmaGrant) begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_wr    = bus.dma_we;
            bus.mem_rd    = !bus.dma_we;
        end

        bus.cpu_stall = bus.cpu_req && dmaGrant;
        bus.cpu_rdata = bus.mem_rdata;
    end

    // Next state and starvation bookkeeping
    always_comb begin
        stateNext  = state;
        starveNext = starveCnt;

        case (state)
            READY:   if (dmaGrant) stateNext = ACK;
            ACK:     stateNext = READY;  // ack cycle never re-issues
            default: stateNext = READY;
        endcase

        // The counter only measures an uninterrupted run of CPU wins while
        // DMA is actually waiting; anything else restarts it.
        if (dmaGrant || !dmaEligible) begin
            starveNext = '0;
        end else if (cpuGrant && (starveCnt < CW'(STARVE_MAX))) begin
            starveNext = starveCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= READY;
            starveCnt <= '0;
            ackReg    <= 1'b0;
            rdataReg  <= 32'h0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveNext;
            ackReg    <= dmaGrant;
            if (dmaGrant && !bus.dma_we) begin
                rdataReg <= bus.mem_rdata;
            end
        end
    end

    assign bus.dma_ack   = ackReg;
    assign bus.dma_rdata = rdataReg;
    assign dbgState      = state;
    assign dbgStarveCnt  = DBG_CNT_W'(starveCnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (STARVE_MAX = 4, AW = 32). Expected DMA read
// data is queued when a DMA access is issued and popped on dma_ack.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic reset;
    arbState_t  dbgState;
    logic [7:0] dbgStarveCnt;

    mem_arbiter_if #(.AW(32)) bus ();

    mem_arbiter #(.STARVE_MAX(4), .AW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .dbgState     (dbgState),
        .dbgStarveCnt (dbgStarveCnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] dmaModel;   // last DMA read value, for write accesses

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 32'h0;
        bus.dma_wdata = 32'h0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic expect_ack(input string tag);
        logic [31:0] e;
        check({tag, "_ack"}, {31'h0, bus.dma_ack}, 32'h1);
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'h0, 32'h1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, bus.dma_rdata, e);
        end
    endtask

    initial begin
        int slot;
        logic [31:0] r;
        dmaModel = 32'h0;
        idle_inputs();
        reset = 1'b1;

        // reset state
        #2;
        check("rst_ack",   {31'h0, bus.dma_ack}, 32'h0);
        check("rst_rdata", bus.dma_rdata, 32'h0);
        check("rst_state", {31'h0, dbgState}, {31'h0, READY});
        check("rst_cnt",   {24'h0, dbgStarveCnt}, 32'h0);
        check("rst_rd",    {31'h0, bus.mem_rd}, 32'h0);
        step();
        step();
        reset = 1'b0;

        // idle
        #1;
        check("idle_rd",   {31'h0, bus.mem_rd}, 32'h0);
        check("idle_wr",   {31'h0, bus.mem_wr}, 32'h0);
        check("idle_addr", bus.mem_addr, 32'h0);
        check("idle_wd",   bus.mem_wdata, 32'h0);
        step();
        step();
        check("idle_cnt",  {24'h0, dbgStarveCnt}, 32'h0);

        // CPU only read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        check("cpu_rd_rd",    {31'h0, bus.mem_rd}, 32'h1);
        check("cpu_rd_wr",    {31'h0, bus.mem_wr}, 32'h0);
        check("cpu_rd_addr",  bus.mem_addr, 32'h10);
        check("cpu_rd_data",  bus.cpu_rdata, 32'hDEADBEEF);
        check("cpu_rd_stall", {31'h0, bus.cpu_stall}, 32'h0);
        step();

        // CPU only write
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h14; bus.cpu_wdata = 32'hA5A5_0F0F;
        #1;
        check("cpu_wr_wr",   {31'h0, bus.mem_wr}, 32'h1);
        check("cpu_wr_rd",   {31'h0, bus.mem_rd}, 32'h0);
        check("cpu_wr_addr", bus.mem_addr, 32'h14);
        check("cpu_wr_wd",   bus.mem_wdata, 32'hA5A5_0F0F);
        step();

        // DMA only write, request held through ACK, re-issued the cycle after
        idle_inputs();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1;
        bus.dma_addr = 32'h20; bus.dma_wdata = 32'h12345678;
        #1;
        check("dma_wr_wr",   {31'h0, bus.mem_wr}, 32'h1);
        check("dma_wr_addr", bus.mem_addr, 32'h20);
        check("dma_wr_wd",   bus.mem_wdata, 32'h12345678);
        exp_q.push_back(dmaModel);
        step();
        expect_ack("dma_wr");
        check("dma_wr_state", {31'h0, dbgState}, {31'h0, ACK});
        check("dma_wr_noacc", {30'h0, bus.mem_rd, bus.mem_wr}, 32'h0);
        step();
        check("dma_reissue_wr",  {31'h0, bus.mem_wr}, 32'h1);
        check("dma_reissue_ack", {31'h0, bus.dma_ack}, 32'h0);
        exp_q.push_back(dmaModel);
        step();
        bus.dma_req = 1'b0;
        expect_ack("dma_reissue");
        step();
        check("dma_wr_ack_low", {31'h0, bus.dma_ack}, 32'h0);

        // DMA only read
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h40;
        bus.mem_rdata = 32'hCAFEF00D;
        #1;
        check("dma_rd_rd",   {31'h0, bus.mem_rd}, 32'h1);
        check("dma_rd_addr", bus.mem_addr, 32'h40);
        exp_q.push_back(32'hCAFEF00D);
        dmaModel = 32'hCAFEF00D;
        step();
        bus.dma_req = 1'b0;
        bus.mem_rdata = 32'h11111111;
        expect_ack("dma_rd");
        step();
        check("dma_rd_hold",    bus.dma_rdata, 32'hCAFEF00D);
        check("dma_rd_ack_low", {31'h0, bus.dma_ack}, 32'h0);
        step();

        // contention: CPU wins slots 0-3, DMA slot 4, ack + CPU slot 5
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h200;
        for (int k = 0; k < 12; k++) begin
            slot = k % 6;
            r = $urandom();
            bus.mem_rdata = r;
            #1;
            check($sformatf("cont%0d_stall", k), {31'h0, bus.cpu_stall}, (slot == 4) ? 32'h1 : 32'h0);
            check($sformatf("cont%0d_addr", k), bus.mem_addr, (slot == 4) ? 32'h200 : 32'h100);
            check($sformatf("cont%0d_cnt", k), {24'h0, dbgStarveCnt},
                  (slot < 5) ? slot : 0);
            if (slot == 5) begin
                expect_ack($sformatf("cont%0d", k));
            end else begin
                check($sformatf("cont%0d_noack", k), {31'h0, bus.dma_ack}, 32'h0);
            end
            if (slot == 4) begin
                exp_q.push_back(r);
                dmaModel = r;
            end
            step();
        end

        // DMA request withdrawn before grant: discarded, no ack
        idle_inputs();
        step();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h300;
        bus.dma_req = 1'b1; bus.dma_addr = 32'h400;
        step();
        step();
        check("drop_cnt2", {24'h0, dbgStarveCnt}, 32'h2);
        bus.dma_req = 1'b0;
        step();
        check("drop_cnt0", {24'h0, dbgStarveCnt}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drop_noack%0d", k), {31'h0, bus.dma_ack}, 32'h0);
            step();
        end

        // reset during ACK suppresses the ack; request re-issued afterwards
        idle_inputs();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h44;
        bus.mem_rdata = 32'h5555AAAA;
        step();
        check("rstack_state", {31'h0, dbgState}, {31'h0, ACK});
        reset = 1'b1;
        #1;
        check("rstack_ack",   {31'h0, bus.dma_ack}, 32'h0);
        check("rstack_st",    {31'h0, dbgState}, {31'h0, READY});
        check("rstack_cnt",   {24'h0, dbgStarveCnt}, 32'h0);
        check("rstack_comb",  {31'h0, bus.mem_rd}, 32'h1);
        step();
        reset = 1'b0;
        bus.mem_rdata = 32'h0BADF00D;
        #1;
        check("rstack_regrant", {31'h0, bus.mem_rd}, 32'h1);
        exp_q.push_back(32'h0BADF00D);
        step();
        bus.dma_req = 1'b0;
        expect_ack("rstack");
        step();

        check("queue_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive CPU wins over a pending DMA request.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_req  input  1  MEM-stage access request (MemRead_MEM | MemWrite_MEM).
REQ-006 SHALL have port cpu_we  input  1  CPU write enable.
REQ-007 SHALL have port cpu_addr / cpu_wdata  input  AW / 32  CPU address and write data.
REQ-008 SHALL have port cpu_rdata  output  32  CPU read data, combinational from mem_rdata.
REQ-009 SHALL have port cpu_stall  output  1  CPU pipeline freeze request.
REQ-010 SHALL have port dma_req / dma_we  input  1 / 1  loader request (held until ack) and write enable.
REQ-011 SHALL have port dma_addr / dma_wdata  input  AW / 32  loader address and write data.
REQ-012 SHALL have port dma_rdata  output  32  registered loader read data.
REQ-013 SHALL have port dma_ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port mem_addr / mem_wdata  output  AW / 32  shared data-memory address and write data.
REQ-015 SHALL have ports mem_rd / mem_wr  output  1 / 1  memory read and write strobes.
REQ-016 SHALL have port mem_rdata  input  32  combinational read data from data memory.

Function
REQ-017 SHALL resolve one owner per cycle, combinationally, from inputs and registered state.
REQ-018 SHALL make DMA eligible only when dma_req=1 and state=READY.
REQ-019 SHALL grant CPU when cpu_req=1 and (DMA ineligible or starve_cnt<STARVE_MAX); otherwise SHALL grant DMA if eligible; else no owner.
REQ-020 SHALL drive mem_* from the granted port; with no owner, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-021 SHALL assert cpu_stall=1 exactly when cpu_req=1 and DMA owns the cycle.
REQ-022 SHALL, on a DMA grant, register mem_rdata into dma_rdata (reads only; writes keep the old value) and move READY->ACK.
REQ-023 SHALL pulse dma_ack=1 in the ACK cycle, then return ACK->READY unconditionally.
REQ-024 SHALL keep dma_ack a registered output, so the access-to-ack latency is exactly 1 cycle.
REQ-025 SHALL increment starve_cnt (saturating at STARVE_MAX) when the CPU wins while DMA is eligible.
REQ-026 SHALL clear starve_cnt on any DMA grant, and on any cycle where DMA is ineligible.
REQ-027 SHALL perform at most one memory access per cycle; cpu_we and dma_we select mem_wr vs mem_rd.
REQ-028 Boundary: if dma_req stays high during ACK, SHALL not re-issue in that cycle; a new DMA access is possible the cycle after.
REQ-029 Boundary: with cpu_req held high continuously and dma_req pending, DMA SHALL get 1 slot per STARVE_MAX+2 cycles.
REQ-030 Boundary: if dma_req drops before its grant, SHALL discard it with no ack.

Reset
REQ-031 On reset SHALL set: state=READY, starve_cnt=0, dma_ack=0, dma_rdata=0.
REQ-032 During reset, combinational outputs SHALL follow REQ-019/020 with starve_cnt=0.
REQ-033 Reset asserted in ACK SHALL suppress that ack; the requester re-issues.

Structure
REQ-034 SHALL place the state encoding (READY=0, ACK=1) and the STARVE_MAX default in the shared CPU package.
REQ-035 SHALL be a single module with no sub-modules, instantiated between EX_MEM outputs and DataMemory.
REQ-036 The top level SHALL OR cpu_stall into the PC/IF_ID/ID_EX/EX_MEM hold logic.

Verification
REQ-037 CPU only: cpu_req=1, read addr 0x10, mem_rdata=0xDEADBEEF -> same cycle mem_rd=1, cpu_rdata=0xDEADBEEF, cpu_stall=0.
REQ-038 DMA only: write addr 0x20, data 0x12345678 -> mem_wr=1 in cycle N, dma_ack=1 in N+1 only, no access in N+1.
REQ-039 Contention, STARVE_MAX=4: both requests held -> CPU wins cycles 0-3, DMA wins cycle 4 with cpu_stall=1, ack in 5, CPU wins 5.
REQ-040 DMA read addr 0x40, mem_rdata=0xCAFEF00D -> dma_rdata=0xCAFEF00D with dma_ack; value held after.
REQ-041 Reset pulse during ACK -> dma_ack=0, starve_cnt=0, state READY; next dma_req granted when no CPU request.
REQ-042 Idle: no requests -> mem_rd=mem_wr=0, mem_addr=0, starve_cnt stays 0.
